tick_generator: RTL and testbench
=================================

Name: tick_generator

Overview:
- Parametrised multi-channel periodic tick generator; successor to the fixed 1 ms / refresh divider in the stopwatch path.
- Each channel counts enabled clock cycles and emits a one-cycle pulse every DIV cycles.
- Divisors are runtime-programmable, glitch-free via shadow registers, with per-channel periodic or one-shot mode.
- Feeds the stopwatch time base, the display refresh scan, and any future timed logic.

Parameters:
- NUM_CH, 2, number of independent tick channels (1..8).
- DIV_W, 17, divisor and counter width in bits (must hold max divisor).
- DIV_INIT, {17'd12500, 17'd100000}, packed NUM_CH*DIV_W reset divisors; channel 0 in the LSBs (ch0 = 1 ms, ch1 = refresh at 100 MHz).
- MODE_INIT, {NUM_CH{1'b0}}, reset mode per channel: 0 = periodic, 1 = one-shot.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- en  in  1  global count enable; low = all counters hold.
- sync  in  1  synchronous restart of all channels.
- cfg_we  in  1  configuration write strobe.
- cfg_ch  in  $clog2(NUM_CH) (min 1)  target channel of the write.
- cfg_div  in  DIV_W  new divisor.
- cfg_mode  in  1  new mode for the target channel.
- tick  out  NUM_CH  one-cycle tick pulses, registered.
- running  out  NUM_CH  1 = channel in RUN state.

Behaviour:
- Reset (reset==0 at edge):
  - count = 0, tick = 0, running = all 1.
  - active_div = pending_div = DIV_INIT, mode = MODE_INIT.
- Effective divisor: active_div == 0 is treated as 1.
- Per channel, on each edge with sync = 0 and en = 1 in RUN:
  - count == eff_div-1: count <= 0, tick <= 1, active_div <= pending_div.
  - otherwise: count <= count+1, tick <= 0.
- Timing:
  - With en high from the first edge after reset release, the first tick is visible after edge DIV.
  - Period is exactly DIV enabled cycles.
  - DIV = 1 gives tick high on every enabled cycle.
- en = 0: count and state hold, tick <= 0. Ticks are never stretched or queued.
- sync = 1 has priority over en and cfg-driven state changes. All channels:
  - count <= 0, tick <= 0.
  - active_div <= pending_div (after this cycle's cfg write).
  - state <= RUN.
- Config write (cfg_we = 1, cfg_ch < NUM_CH):
  - pending_div[ch] <= cfg_div, mode[ch] <= cfg_mode.
  - A one-shot channel in IDLE re-arms: RUN, count <= 0.
- Config write with cfg_ch >= NUM_CH: ignored, no state change.
- Config write in the same cycle as that channel's wrap: the new cfg_div bypasses into active_div, so the next period uses it.
- Config write mid-period: does not disturb the current period; the new divisor applies from the next wrap.
- Channel state machine:
  - States: RUN, IDLE.
  - Periodic mode: always RUN.
  - One-shot mode: RUN -> IDLE on the edge issuing its tick. In IDLE, count holds at 0, tick = 0, running = 0.
  - IDLE -> RUN on config write to that channel or on sync.
- Wrap-around: count never exceeds eff_div-1.
- A divisor lowered below the current count takes effect only at wrap, because it is only loaded at wrap, sync or bypass.
- Reset mid-operation: every channel returns to reset values in one edge. No tick is emitted on the reset edge.

Optional Feature:
- Macro: TICK_GEN_SQUARE_EN.
- Defined:
  - Adds output port sq [NUM_CH], registered, reset 0.
  - sq[i] toggles on every edge that sets tick[i], giving a 50% square wave at half the tick rate.
  - sync clears sq to 0. en low holds sq.
- Undefined: the port and its flops are absent; all other behaviour is identical.

Decomposition:
- Package tick_gen_pkg:
  - Mode encoding constants MODE_PERIODIC = 1'b0, MODE_ONESHOT = 1'b1.
  - State encoding RUN / IDLE.
  - Default divisor constants DIV_1MS_100MHZ = 100000 and DIV_REFRESH_100MHZ = 12500.
- Sub-module tick_channel: one counter, shadow and state machine.
  - Ports: clk, reset, en, sync, wr, wr_div, wr_mode, tick, running (plus sq under the macro).
  - Instantiated NUM_CH times in a generate loop.
  - The top does cfg_ch decode and range check only.

Test Plan:
- Default params, reset low for 3 cycles then high, en = 1: tick[0] first high after edge 100000, then every 100000 cycles; tick[1] every 12500; running = 2'b11.
- Program ch1 div = 5 mid-period at count 3000: the current 12500 period completes, then ticks arrive every 5 cycles. Repeat with the write landing on the wrap cycle: the next period is 5 cycles.
- Write ch0 div = 4 mode = one-shot: exactly one tick 4 cycles after the current wrap, then running[0] = 0 and no further ticks. Another cfg write re-arms, next tick after 4 cycles.
- Toggle en low for 7 cycles in a div = 10 channel: the tick is delayed by exactly 7 cycles and no pulse occurs while en is low. Assert sync while en = 0: count cleared, first tick 10 enabled cycles after.
- div = 0 and div = 1: tick high on every enabled cycle. cfg_ch = 3 with NUM_CH = 2: no change observed on any channel.
- TICK_GEN_SQUARE_EN defined, div = 3: sq toggles every 3 cycles (period 6). Reset low mid-run: tick, sq and count all return to 0 on the reset edge.

Source files
------------

// File: rtl/tick_gen_pkg.sv
// Shared definitions for the tick generator: mode and channel-state encodings,
// the 100 MHz default divisors and a helper sizing the channel-select field.
package tick_gen_pkg;

  localparam logic MODE_PERIODIC = 1'b0;
  localparam logic MODE_ONESHOT  = 1'b1;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_IDLE = 1'b1
  } ch_state_e;

  // 100 MHz system clock: 1 ms time base and display refresh scan.
  localparam int unsigned DIV_1MS_100MHZ     = 100000;
  localparam int unsigned DIV_REFRESH_100MHZ = 12500;

  // Width of a channel index; never narrower than one bit.
  function automatic int unsigned ch_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tick_generator_if.sv
// Configuration write bus of the tick generator.
//   cfg_we   : write strobe
//   cfg_ch   : target channel (writes to a channel >= NUM_CH are dropped)
//   cfg_div  : new divisor (0 behaves as 1)
//   cfg_mode : new mode, 0 = periodic, 1 = one-shot
// master drives the bus, slave (the generator) receives it.
interface tick_generator_if
  import tick_gen_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int DIV_W  = 17
);
  localparam int CH_W = ch_idx_w(NUM_CH);

  logic             cfg_we;
  logic [CH_W-1:0]  cfg_ch;
  logic [DIV_W-1:0] cfg_div;
  logic             cfg_mode;

  modport master (output cfg_we, output cfg_ch, output cfg_div, output cfg_mode);
  modport slave  (input  cfg_we, input  cfg_ch, input  cfg_div, input  cfg_mode);
endinterface

// File: rtl/tick_generator_channel.sv
// tick_channel: one tick channel -- enabled-cycle counter, shadow divisor and
// RUN/IDLE state machine.
//   clk, reset (sync, active-low), en (count enable), sync (restart)
//   wr, wr_div, wr_mode : decoded configuration write for this channel
//   tick    : registered one-cycle pulse at each period end
//   running : channel is in RUN
//   sq      : square wave toggling on each tick (TICK_GEN_SQUARE_EN only)
// The programmed divisor/mode sit in a shadow (pend_*) and are copied into the
// active pair only at a wrap, on sync, or on re-arm, so a period in progress
// is never disturbed by a write.
module tick_channel
  import tick_gen_pkg::*;
#(
  parameter int               DIV_W    = 17,
  parameter logic [DIV_W-1:0] DIV_RST  = DIV_W'(1),
  parameter logic             MODE_RST = MODE_PERIODIC
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             sync,
  input  logic             wr,
  input  logic [DIV_W-1:0] wr_div,
  input  logic             wr_mode,
  output logic             tick,
  output logic             running
`ifdef TICK_GEN_SQUARE_EN
  ,
  output logic             sq
`endif
);

  logic [DIV_W-1:0] count_q, count_d;
  logic [DIV_W-1:0] act_div_q, act_div_d;
  logic [DIV_W-1:0] pend_div_q, pend_div_d;
  logic             act_mode_q, act_mode_d;
  logic             pend_mode_q, pend_mode_d;
  ch_state_e        state_q, state_d;
  logic             tick_q, tick_d;
  logic [DIV_W-1:0] last_cnt;

  always_comb begin
    // A divisor of 0 behaves as 1, so both end the period at count 0.
    last_cnt    = (act_div_q == '0) ? '0 : act_div_q - 1'b1;
    // Shadow values after this cycle's write; also the bypass source at wrap.
    pend_div_d  = wr ? wr_div  : pend_div_q;
    pend_mode_d = wr ? wr_mode : pend_mode_q;
    count_d     = count_q;
    act_div_d   = act_div_q;
    act_mode_d  = act_mode_q;
    state_d     = state_q;
    tick_d      = 1'b0;
    if (sync) begin
      count_d    = '0;
      act_div_d  = pend_div_d;
      act_mode_d = pend_mode_d;
      state_d    = ST_RUN;
    end else if (state_q == ST_IDLE) begin
      // Re-arm takes the written divisor/mode straight away.
      if (wr) begin
        count_d    = '0;
        act_div_d  = wr_div;
        act_mode_d = wr_mode;
        state_d    = ST_RUN;
      end
    end else if (en) begin
      if (count_q == last_cnt) begin
        count_d    = '0;
        tick_d     = 1'b1;
        act_div_d  = pend_div_d;
        act_mode_d = pend_mode_d;
        // The one-shot decision belongs to the period that just ended.
        if (act_mode_q == MODE_ONESHOT) state_d = ST_IDLE;
      end else begin
        count_d = count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q     <= '0;
      act_div_q   <= DIV_RST;
      pend_div_q  <= DIV_RST;
      act_mode_q  <= MODE_RST;
      pend_mode_q <= MODE_RST;
      state_q     <= ST_RUN;
      tick_q      <= 1'b0;
    end else begin
      count_q     <= count_d;
      act_div_q   <= act_div_d;
      pend_div_q  <= pend_div_d;
      act_mode_q  <= act_mode_d;
      pend_mode_q <= pend_mode_d;
      state_q     <= state_d;
      tick_q      <= tick_d;
    end
  end

  assign tick    = tick_q;
  assign running = (state_q == ST_RUN);

`ifdef TICK_GEN_SQUARE_EN
  logic sq_q, sq_d;

  always_comb begin
    sq_d = sq_q;
    if (sync)        sq_d = 1'b0;
    else if (tick_d) sq_d = ~sq_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) sq_q <= 1'b0;
    else        sq_q <= sq_d;
  end

  assign sq = sq_q;
`endif

endmodule

// File: rtl/tick_generator.sv
// tick_generator: multi-channel periodic / one-shot tick generator.
//   clk      : system clock (rising edge)
//   reset    : synchronous, active-low
//   en       : global count enable (low = all counters hold)
//   sync     : synchronous restart of all channels
//   cfg      : configuration write bus (tick_generator_if.slave)
//   tick     : one-cycle registered tick per channel
//   running  : channel in RUN state
//   sq       : per-channel square wave at half the tick rate, present only
//              when the macro TICK_GEN_SQUARE_EN is defined
// This level only decodes cfg_ch; everything else lives in tick_channel.
module tick_generator
  import tick_gen_pkg::*;
#(
  parameter int                      NUM_CH    = 2,
  parameter int                      DIV_W     = 17,
  parameter logic [NUM_CH*DIV_W-1:0] DIV_INIT  = {DIV_W'(DIV_REFRESH_100MHZ),
                                                  DIV_W'(DIV_1MS_100MHZ)},
  parameter logic [NUM_CH-1:0]       MODE_INIT = {NUM_CH{MODE_PERIODIC}}
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              sync,
  tick_generator_if.slave   cfg,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] running
`ifdef TICK_GEN_SQUARE_EN
  ,
  output logic [NUM_CH-1:0] sq
`endif
);

  localparam int CH_W = ch_idx_w(NUM_CH);

  logic [NUM_CH-1:0] wr;

  // Indices >= NUM_CH match no channel, so such writes are dropped.
  always_comb begin
    wr = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      wr[i] = cfg.cfg_we && (cfg.cfg_ch == CH_W'(i));
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    tick_channel #(
      .DIV_W   (DIV_W),
      .DIV_RST (DIV_INIT[i*DIV_W +: DIV_W]),
      .MODE_RST(MODE_INIT[i])
    ) u_ch (
      .clk    (clk),
      .reset  (reset),
      .en     (en),
      .sync   (sync),
      .wr     (wr[i]),
      .wr_div (cfg.cfg_div),
      .wr_mode(cfg.cfg_mode),
      .tick   (tick[i]),
      .running(running[i])
`ifdef TICK_GEN_SQUARE_EN
      ,
      .sq     (sq[i])
`endif
    );
  end

endmodule

// File: tb/tb_tick_generator.sv
// Randomized bench for tick_generator with a cycle-level reference model.
// Three channels (so that cfg_ch = 3 is an out-of-range index) and short
// divisors keep the run short.
module tb_tick_generator;

  localparam int NC = 3;
  localparam int DW = 8;
  localparam logic [NC*DW-1:0] TB_DIV_INIT  = {8'd7, 8'd12, 8'd20};
  localparam logic [NC-1:0]    TB_MODE_INIT = 3'b000;

  logic clk = 1'b0;
  logic reset, en, sync;
  logic [NC-1:0] tick, running;
  logic [NC-1:0] sq_obs;

  tick_generator_if #(.NUM_CH(NC), .DIV_W(DW)) cfg_if ();

  tick_generator #(
    .NUM_CH   (NC),
    .DIV_W    (DW),
    .DIV_INIT (TB_DIV_INIT),
    .MODE_INIT(TB_MODE_INIT)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .sync   (sync),
    .cfg    (cfg_if),
    .tick   (tick),
    .running(running)
`ifdef TICK_GEN_SQUARE_EN
    ,
    .sq     (sq_obs)
`endif
  );

`ifndef TICK_GEN_SQUARE_EN
  assign sq_obs = '0;
`endif

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: per channel, the programmed (pend) and in-force (act)
  // divisor/mode, elapsed enabled cycles in the current period, armed flag.
  int pend_div[NC], act_div[NC], elapsed[NC];
  bit pend_mode[NC], act_mode[NC], armed[NC];
  bit exp_tick[NC], exp_sq[NC];

  task automatic model_edge(input bit r, input bit e, input bit s, input bit we,
                            input int ch, input int dv, input bit md);
    for (int c = 0; c < NC; c++) begin
      bit hit;
      int nd;
      bit nm;
      int period;
      hit = we && (ch == c);
      exp_tick[c] = 1'b0;
      if (!r) begin
        pend_div[c]  = int'(TB_DIV_INIT[c*DW +: DW]);
        act_div[c]   = pend_div[c];
        pend_mode[c] = TB_MODE_INIT[c];
        act_mode[c]  = TB_MODE_INIT[c];
        armed[c]     = 1'b1;
        elapsed[c]   = 0;
        exp_sq[c]    = 1'b0;
      end else begin
        nd = hit ? dv : pend_div[c];
        nm = hit ? md : pend_mode[c];
        if (s) begin
          elapsed[c]  = 0;
          act_div[c]  = nd;
          act_mode[c] = nm;
          armed[c]    = 1'b1;
          exp_sq[c]   = 1'b0;
        end else if (!armed[c]) begin
          if (hit) begin
            armed[c]    = 1'b1;
            elapsed[c]  = 0;
            act_div[c]  = dv;
            act_mode[c] = md;
          end
        end else if (e) begin
          period = (act_div[c] == 0) ? 1 : act_div[c];
          if (elapsed[c] + 1 >= period) begin
            exp_tick[c] = 1'b1;
            exp_sq[c]   = ~exp_sq[c];
            elapsed[c]  = 0;
            if (act_mode[c]) armed[c] = 1'b0;
            act_div[c]  = nd;
            act_mode[c] = nm;
          end else begin
            elapsed[c]++;
          end
        end
        pend_div[c]  = nd;
        pend_mode[c] = nm;
      end
    end
  endtask

  function automatic logic [NC-1:0] pack(input bit v[NC]);
    logic [NC-1:0] p;
    for (int c = 0; c < NC; c++) p[c] = v[c];
    return p;
  endfunction

  // One clock: drive on the falling edge, advance the model, sample 1 ns
  // after the rising edge.
  task automatic step(input bit r, input bit e, input bit s, input bit we,
                      input int ch, input int dv, input bit md);
    @(negedge clk);
    reset           = r;
    en              = e;
    sync            = s;
    cfg_if.cfg_we   = we;
    cfg_if.cfg_ch   = 2'(ch);
    cfg_if.cfg_div  = 8'(dv);
    cfg_if.cfg_mode = md;
    model_edge(r, e, s, we, ch, dv, md);
    @(posedge clk);
    #1;
    check("tick", 32'(tick), 32'(pack(exp_tick)));
    check("running", 32'(running), 32'(pack(armed)));
`ifdef TICK_GEN_SQUARE_EN
    check("sq", 32'(sq_obs), 32'(pack(exp_sq)));
`endif
  endtask

  task automatic idle_steps(input int n, input bit e);
    for (int k = 0; k < n; k++) step(1'b1, e, 1'b0, 1'b0, 0, 0, 1'b0);
  endtask

  initial begin
    int first_t0;
    reset = 1'b0; en = 1'b0; sync = 1'b0;
    cfg_if.cfg_we = 1'b0; cfg_if.cfg_ch = '0; cfg_if.cfg_div = '0; cfg_if.cfg_mode = 1'b0;

    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
    check("reset_running", 32'(running), 32'h7);
    check("reset_tick", 32'(tick), 32'h0);

    // First ch0 tick (div 20) must appear after the 20th enabled edge.
    first_t0 = -1;
    for (int j = 1; j <= 45; j++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
      if (first_t0 < 0 && tick[0]) first_t0 = j;
    end
    check("first_tick0", 32'(first_t0), 32'd20);

    // Mid-period divisor change on ch1, one-shot on ch0, then re-arm.
    step(1'b1, 1'b1, 1'b0, 1'b1, 1, 5, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 0, 4, 1'b1);
    idle_steps(40, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1, 0, 4, 1'b1);
    idle_steps(10, 1'b1);

    // ch2 div 10, en low for 7 cycles, then sync while en is low.
    step(1'b1, 1'b1, 1'b1, 1'b1, 2, 10, 1'b0);
    idle_steps(4, 1'b1);
    idle_steps(7, 1'b0);
    idle_steps(12, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
    idle_steps(12, 1'b1);

    // div 0, div 1, out-of-range channel write.
    step(1'b1, 1'b1, 1'b1, 1'b1, 2, 0, 1'b0);
    idle_steps(5, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1, 1, 1'b0);
    idle_steps(5, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1, 3, 2, 1'b1);
    idle_steps(8, 1'b1);

    // Square wave on a div-3 channel, then reset mid-run.
    step(1'b1, 1'b1, 1'b1, 1'b1, 0, 3, 1'b0);
    idle_steps(14, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
    idle_steps(3, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      bit r, e, s, we, md;
      int ch, dv;
      r  = ($urandom_range(0, 299) != 0);
      e  = ($urandom_range(0, 9) != 0);
      s  = ($urandom_range(0, 79) == 0);
      we = ($urandom_range(0, 14) == 0);
      ch = $urandom_range(0, 3);
      dv = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 40) : $urandom_range(0, 6);
      md = ($urandom_range(0, 3) == 0);
      step(r, e, s, we, ch, dv, md);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
